// File: rtl/dds_ctrl_pkg.sv
// Shared types and widths for the DDS sweep controller.
package dds_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SWEEP,
        ST_DONE
    } state_e;

    localparam int unsigned PAD_W = 16;
    localparam int unsigned DDS_W = 32;

    // A zero count is treated as one.
    function automatic logic [15:0] at_least_one(input logic [15:0] v);
        return (v == '0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/dds_lut_loader.sv
// LUT load handshake: accepts upstream samples and issues one DDS LUT write per beat.
module dds_lut_loader
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             active_i,
    input  logic             abort_i,
    input  logic             lut_valid_i,
    input  logic [15:0]      lut_data_i,
    output logic             lut_ready_o,
    output logic             last_o,
    output logic             we_o,
    output logic [DDS_W-1:0] addr_o,
    output logic [DDS_W-1:0] data_o
);

    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  we_q;
    logic [DDS_W-1:0]      addr_q;
    logic [DDS_W-1:0]      data_q;
    logic                  accept;

    // A beat coinciding with abort is dropped so no strobe follows the abort.
    assign accept      = active_i && lut_valid_i && !abort_i;
    assign last_o      = accept && (cnt_q == '1);
    assign lut_ready_o = active_i;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= accept;
            if (clear_i) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) begin
                addr_q <= DDS_W'(cnt_q);
                data_q <= {{PAD_W{1'b0}}, lut_data_i};
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS sweep controller: loads the DDS LUT, settles, then steps the tuning word.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        lut_valid,
    input  logic [15:0] lut_data,
    output logic        lut_ready,
    input  logic [31:0] f_start,
    input  logic [31:0] f_step,
    input  logic [15:0] dwell,
    input  logic [15:0] n_freqs,
    output logic        LUTWe,
    output logic [31:0] LUTAddress,
    output logic [31:0] LUTData,
    output logic        en,
    output logic [31:0] FreqCntrl,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;

    state_e           state_q;
    logic [DDS_W-1:0] freq_q;
    logic [DDS_W-1:0] step_q;
    logic [15:0]      dwell_q;
    logic [15:0]      nfreq_q;
    logic [15:0]      dwell_cnt_q;
    logic [15:0]      freq_idx_q;
    logic [31:0]      settle_cnt_q;
    logic             en_q;
    logic             done_q;
    logic             load_clear;
    logic             load_last;

    assign load_clear = (state_q == ST_IDLE) && start && !abort;
    assign busy       = (state_q != ST_IDLE);
    assign en         = en_q;
    assign done       = done_q;
    assign FreqCntrl  = freq_q;

    dds_lut_loader #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (load_clear),
        .active_i   (state_q == ST_LOAD),
        .abort_i    (abort),
        .lut_valid_i(lut_valid),
        .lut_data_i (lut_data),
        .lut_ready_o(lut_ready),
        .last_o     (load_last),
        .we_o       (LUTWe),
        .addr_o     (LUTAddress),
        .data_o     (LUTData)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            freq_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            nfreq_q      <= '0;
            dwell_cnt_q  <= '0;
            freq_idx_q   <= '0;
            settle_cnt_q <= '0;
            en_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                en_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            freq_q  <= f_start;
                            step_q  <= f_step;
                            dwell_q <= at_least_one(dwell);
                            nfreq_q <= at_least_one(n_freqs);
                            en_q    <= 1'b0;
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (load_last) begin
                            settle_cnt_q <= '0;
                            state_q      <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_q >= 32'(SETTLE_LAST)) begin
                            dwell_cnt_q <= '0;
                            freq_idx_q  <= '0;
                            en_q        <= 1'b1;
                            state_q     <= ST_SWEEP;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 32'd1;
                        end
                    end
                    ST_SWEEP: begin
                        if (dwell_cnt_q == dwell_q - 16'd1) begin
                            dwell_cnt_q <= '0;
                            if (freq_idx_q == nfreq_q - 16'd1) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                freq_q     <= freq_q + step_q;
                                freq_idx_q <= freq_idx_q + 16'd1;
                            end
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q + 16'd1;
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, DDS LUT depth is 2^ADDR_WIDTH words.
REQ-002 Parameter SETTLE_CYCLES, default 4, idle cycles between LUT load end and sweep start.
REQ-003 One clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  pulse: begin LUT load then sweep.
REQ-007 abort  in  1  pulse: cancel current operation.
REQ-008 lut_valid  in  1  upstream LUT sample valid.
REQ-009 lut_data  in  16  upstream LUT sample.
REQ-010 lut_ready  out  1  controller accepts LUT sample.
REQ-011 f_start  in  32  first frequency word.
REQ-012 f_step  in  32  signed two's-complement frequency increment.
REQ-013 dwell  in  16  cycles per frequency (0 treated as 1).
REQ-014 n_freqs  in  16  frequencies in sweep including f_start (0 treated as 1).
REQ-015 LUTWe  out  1  DDS LUT write strobe.
REQ-016 LUTAddress  out  32  DDS LUT write address.
REQ-017 LUTData  out  32  DDS LUT write data.
REQ-018 en  out  1  DDS enable.
REQ-019 FreqCntrl  out  32  DDS frequency tuning word.
REQ-020 busy  out  1  high whenever state is not IDLE.
REQ-021 done  out  1  one-cycle pulse at sweep completion.

Function
REQ-022 States IDLE, LOAD, SETTLE, SWEEP, DONE; busy = (state != IDLE).
REQ-023 IDLE: start -> LOAD; f_start, f_step, dwell, n_freqs registered on that edge; en cleared; address counter cleared.
REQ-024 start while busy is ignored; configuration inputs are ignored outside the start edge.
REQ-025 LOAD: lut_ready = 1; a beat is accepted when lut_valid && lut_ready; throughput one beat per cycle.
REQ-026 Each accepted beat produces LUTWe = 1 on the next cycle only, with LUTAddress = beat index (0 upward) and LUTData = {16'h0000, lut_data}.
REQ-027 Accepting beat index 2^ADDR_WIDTH-1 -> SETTLE next cycle; lut_ready = 0 from that cycle; its write strobe still issues.
REQ-028 SETTLE: en = 0, FreqCntrl = f_start; after SETTLE_CYCLES cycles -> SWEEP.
REQ-029 SWEEP: en = 1; each frequency is held for exactly dwell cycles, then FreqCntrl <= FreqCntrl + f_step modulo 2^32 (wrap, no saturation).
REQ-030 After the dwell of frequency n_freqs -> DONE; FreqCntrl is not advanced past the last frequency.
REQ-031 DONE: done = 1 for one cycle -> IDLE; en stays 1 and FreqCntrl holds the last frequency until the next start or abort.
REQ-032 abort in any non-IDLE state -> IDLE next cycle; en = 0, LUTWe = 0, lut_ready = 0, no done pulse.
REQ-033 abort and start in the same cycle: abort wins; start is dropped.
REQ-034 abort in IDLE clears en; FreqCntrl is unchanged.

Reset
REQ-035 rst_n low: state = IDLE, all outputs 0, all counters 0, immediately and asynchronously.
REQ-036 Reset mid-operation discards all progress; after release the block waits for start.

Structure
REQ-037 Package dds_ctrl_pkg holds the state encoding, LUT data pad width (16) and DDS word width (32).
REQ-038 One sub-module, dds_lut_loader, owns the LOAD handshake, address counter and write-strobe register.

Verification
REQ-039 ADDR_WIDTH=4, start, lut_data 0x1000+i with continuous valid -> 16 LUTWe pulses, addresses 0..15, LUTData 0x00001000+i, 4 cycles en=0, then en=1.
REQ-040 f_start=50000, f_step=50000, dwell=3, n_freqs=3 -> FreqCntrl 50000, 100000, 150000 for 3 cycles each, done pulse, then IDLE with FreqCntrl=150000.
REQ-041 lut_valid high every other cycle -> LUTWe only after accepted beats, addresses contiguous 0..15, no gaps or duplicates.
REQ-042 f_start=0xFFFFFFF0, f_step=0x20, n_freqs=2 -> second FreqCntrl 0x00000010; f_step=-50000 from 100000 gives 50000.
REQ-043 abort at address 7 during LOAD -> IDLE next cycle, lut_ready=0, no done; the next start restarts at address 0.
REQ-044 rst_n low mid-SWEEP, between clock edges -> en, FreqCntrl, busy all 0 without waiting for a clock edge.
